thread_scheduler: RTL and testbench
===================================

Name: thread_scheduler

Overview:
Barrel-thread scheduler feeding the fetch stage. It owns one word-PC per hardware thread and a small per-thread state machine. Each cycle it picks the next eligible thread round-robin and drives that thread id and PC to the IFU, so one thread per slot shares the single fetch/execute datapath. It accepts PC writebacks from EXU and thread start/stop commands from the control/CSR logic.

Parameters:
NUM_THREADS, 4, number of hardware threads; power of two, ≥2.
TID_W, $clog2(NUM_THREADS) = 2, thread id width.
PC_W, ADDR_LEN-3, word-PC width; matches the IFU new_pc input.
RESET_PC, '0, PC loaded into thread 0 at reset.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-low (0 = reset).
stall  in  1  fetch stall; hold outputs, no new issue.
issue_valid  out  1  thread_id/issue_pc valid this cycle.
thread_id  out  TID_W  selected thread, to IFU thread_id.
issue_pc  out  PC_W  selected thread's PC, to IFU new_pc.
wb_valid  in  1  EXU next-PC writeback.
wb_tid  in  TID_W  writeback thread.
wb_pc  in  PC_W  thread's next PC.
wb_halt  in  1  thread executed halt; park it.
start_valid  in  1  start-thread command.
start_tid  in  TID_W  thread to start.
start_pc  in  PC_W  start PC.
stop_valid  in  1  stop-thread command.
stop_tid  in  TID_W  thread to stop.
cmd_err  out  1  1-cycle pulse: start to a non-IDLE thread.
thread_active  out  NUM_THREADS  bit i = thread i not IDLE/HALTED.

Behaviour:
- Per-thread state: IDLE, READY, INFLIGHT, HALTED. Per-thread kill_pending flag.
- Reset (rst=0 at a clk edge): all PCs = 0; pc[0] = RESET_PC; thread 0 READY; others IDLE; kill_pending = 0; rr_ptr = NUM_THREADS-1 (thread 0 is scanned first). Outputs: issue_valid=0, thread_id=0, issue_pc=0, cmd_err=0, thread_active=0001b. Reset mid-operation discards all in-flight state. Writebacks arriving during reset are ignored.
- Selection (combinational, from registered state): scan threads rr_ptr+1, rr_ptr+2, … modulo NUM_THREADS. Pick the first thread in READY. Wrap-around is required.
- Issue (registered; 1-cycle latency): if stall=0 and a thread is picked:
  - next cycle: issue_valid=1, thread_id=tid, issue_pc=pc[tid];
  - that thread moves READY→INFLIGHT;
  - rr_ptr <= tid.
- No READY thread and stall=0: issue_valid=0; thread_id/issue_pc hold their last values.
- stall=1: all outputs hold, including issue_valid. No state change from selection. Writeback and commands are still processed.
- Writeback (wb_valid=1, thread INFLIGHT): pc[wb_tid] <= wb_pc. Next state:
  - HALTED if wb_halt=1;
  - else IDLE if kill_pending=1 (flag cleared);
  - else READY.
- Writeback to a non-INFLIGHT thread is ignored.
- Writeback at cycle N makes the thread eligible for selection at N+1; its issue appears at N+2.
- A thread cannot be issued and written back in the same cycle: it is INFLIGHT when written back.
- Start: if start_tid is IDLE or HALTED, then pc <= start_pc and state becomes READY. Otherwise the command is ignored and cmd_err pulses next cycle.
- Stop:
  - READY → IDLE.
  - INFLIGHT: set kill_pending; the thread goes IDLE on its writeback, and wb_pc is still stored.
  - IDLE/HALTED: no effect.
- Priority on the same thread in one cycle: writeback first, then stop, then start.
  - Start together with a writeback that makes the thread READY → cmd_err.
  - Stop and start together on an IDLE thread → thread ends READY (start wins).
  - Selection uses pre-update state. A stop on a thread being issued that cycle lands it INFLIGHT with kill_pending set.
- thread_active is registered and updated with state.
- PC arithmetic: none inside the block; PCs are stored verbatim, width PC_W.

Decomposition:
- cpu_types: thread_state_e enum (IDLE, READY, INFLIGHT, HALTED) and tid_t typedef.
- cpu_config: NUM_THREADS.
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs: ready vector and rr_ptr. Outputs: grant_valid and grant_tid.

Test Plan:
1. Release reset, no commands → cycle 1: issue_valid=1, thread_id=0, issue_pc=RESET_PC. Then issue_valid=0 until a writeback for tid 0 arrives.
2. Start threads 1,2,3 at PCs 0x100/0x200/0x300. Return a writeback 1 cycle after each issue, with wb_pc = pc+1 → issued thread_id sequence 0,1,2,3,0,…; each thread's issue_pc increments by 1 per round.
3. Threads 0 and 2 READY, rr_ptr=3, both eligible → grant order 0 then 2 (wrap-around). Assert stall=1 for 3 cycles → outputs frozen, no state change.
4. Stop thread 1 while INFLIGHT, then writeback wb_pc=0x105 → thread 1 IDLE, never re-issued; thread_active[1]=0. Restart at 0x400 → next issue of 1 has issue_pc=0x400.
5. Start to a READY thread → cmd_err=1 for one cycle; that thread's PC is unchanged.
6. wb_halt=1 for thread 0 → HALTED, skipped by the scheduler. Assert reset mid-stream → all outputs return to reset values; only thread 0 issues, at RESET_PC.

Source files
------------

// File: rtl/thread_scheduler_pkg.sv
// Shared types and sizing for the barrel-thread scheduler.
// The IFU's word-PC width is derived from the byte-address width.
package thread_scheduler_pkg;

    localparam int unsigned ADDR_LEN    = 32;
    localparam int unsigned NUM_THREADS = 4;
    localparam int unsigned TID_W       = $clog2(NUM_THREADS);
    localparam int unsigned PC_W        = ADDR_LEN - 3;

    typedef logic [TID_W-1:0] tid_t;
    typedef logic [PC_W-1:0]  pc_t;

    localparam pc_t RESET_PC = '0;

    typedef enum logic [1:0] {
        TS_IDLE,
        TS_READY,
        TS_INFLIGHT,
        TS_HALTED
    } thread_state_e;

    // Payload handed to the IFU on each issue slot
    typedef struct packed {
        tid_t tid;
        pc_t  pc;
    } issue_t;

    // A thread counts as active while it is runnable or has an instruction in flight
    function automatic logic is_live(input thread_state_e s);
        return (s == TS_READY) || (s == TS_INFLIGHT);
    endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Scheduler-facing bundle: issue to IFU, writeback from EXU, start/stop commands.
// master = scheduler side, slave = surrounding pipeline/control side.
interface thread_scheduler_if;
    import thread_scheduler_pkg::*;

    logic                   stall;
    logic                   issue_valid;
    tid_t                   thread_id;
    pc_t                    issue_pc;

    logic                   wb_valid;
    tid_t                   wb_tid;
    pc_t                    wb_pc;
    logic                   wb_halt;

    logic                   start_valid;
    tid_t                   start_tid;
    pc_t                    start_pc;
    logic                   stop_valid;
    tid_t                   stop_tid;
    logic                   cmd_err;
    logic [NUM_THREADS-1:0] thread_active;

    modport master (
        input  stall,
        output issue_valid, thread_id, issue_pc,
        input  wb_valid, wb_tid, wb_pc, wb_halt,
        input  start_valid, start_tid, start_pc,
        input  stop_valid, stop_tid,
        output cmd_err, thread_active
    );

    modport slave (
        output stall,
        input  issue_valid, thread_id, issue_pc,
        output wb_valid, wb_tid, wb_pc, wb_halt,
        output start_valid, start_tid, start_pc,
        output stop_valid, stop_tid,
        input  cmd_err, thread_active
    );

endinterface

// File: rtl/thread_scheduler_rr_pick.sv
// Combinational round-robin picker: first ready thread after rr_ptr, with wrap.
module thread_scheduler_rr_pick
    import thread_scheduler_pkg::*;
(
    input  logic [NUM_THREADS-1:0] i_ready,
    input  tid_t                   i_rr_ptr,
    output logic                   o_grant_valid_c,
    output tid_t                   o_grant_tid_c
);

    logic w_found;
    tid_t w_idx;

    // Scan rr_ptr+1 .. rr_ptr+NUM_THREADS; TID_W truncation gives the modulo wrap
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        o_grant_tid_c = '0;
        for (int unsigned k = 1; k <= NUM_THREADS; k++) begin
            w_idx = TID_W'(32'(i_rr_ptr) + k);
            if (!w_found && i_ready[w_idx]) begin
                w_found       = 1'b1;
                o_grant_tid_c = w_idx;
            end
        end
        o_grant_valid_c = w_found;
    end

endmodule

// File: rtl/thread_scheduler.sv
// Barrel-thread scheduler: per-thread PC/state, round-robin issue to the IFU,
// EXU PC writeback and start/stop command handling.
module thread_scheduler
    import thread_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    thread_scheduler_if.master sif
);

    thread_state_e          r_state [NUM_THREADS];
    thread_state_e          w_state [NUM_THREADS];
    pc_t                    r_pc    [NUM_THREADS];
    pc_t                    w_pc    [NUM_THREADS];
    logic [NUM_THREADS-1:0] r_kill;
    logic [NUM_THREADS-1:0] w_kill;
    tid_t                   r_rr_ptr;
    tid_t                   w_rr_ptr;

    logic                   r_issue_valid;
    logic                   w_issue_valid;
    issue_t                 r_issue;
    issue_t                 w_issue;
    logic                   r_cmd_err;
    logic                   w_cmd_err;
    logic [NUM_THREADS-1:0] r_thread_active;
    logic [NUM_THREADS-1:0] w_thread_active;

    logic [NUM_THREADS-1:0] w_ready;
    logic                   w_grant_valid;
    tid_t                   w_grant_tid;

    // Selection always sees the registered (pre-update) state
    always_comb begin
        w_ready = '0;
        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            w_ready[TID_W'(t)] = (r_state[TID_W'(t)] == TS_READY);
        end
    end

    thread_scheduler_rr_pick u_rr_pick (
        .i_ready         (w_ready),
        .i_rr_ptr        (r_rr_ptr),
        .o_grant_valid_c (w_grant_valid),
        .o_grant_tid_c   (w_grant_tid)
    );

    // Next-state: issue, then writeback, then stop, then start
    always_comb begin
        w_state         = r_state;
        w_pc            = r_pc;
        w_kill          = r_kill;
        w_rr_ptr        = r_rr_ptr;
        w_issue_valid   = r_issue_valid;
        w_issue         = r_issue;
        w_cmd_err       = 1'b0;
        w_thread_active = r_thread_active;

        if (!sif.stall) begin
            w_issue_valid = w_grant_valid;
            if (w_grant_valid) begin
                w_issue.tid          = w_grant_tid;
                w_issue.pc           = r_pc[w_grant_tid];
                w_rr_ptr             = w_grant_tid;
                w_state[w_grant_tid] = TS_INFLIGHT;
            end
        end

        // An issued thread was READY, so it can never also match this INFLIGHT check
        if (sif.wb_valid && (r_state[sif.wb_tid] == TS_INFLIGHT)) begin
            w_pc[sif.wb_tid]   = sif.wb_pc;
            w_kill[sif.wb_tid] = 1'b0;
            if (sif.wb_halt) begin
                w_state[sif.wb_tid] = TS_HALTED;
            end else if (r_kill[sif.wb_tid]) begin
                w_state[sif.wb_tid] = TS_IDLE;
            end else begin
                w_state[sif.wb_tid] = TS_READY;
            end
        end

        if (sif.stop_valid) begin
            if (w_state[sif.stop_tid] == TS_READY) begin
                w_state[sif.stop_tid] = TS_IDLE;
            end else if (w_state[sif.stop_tid] == TS_INFLIGHT) begin
                w_kill[sif.stop_tid] = 1'b1;
            end
        end

        if (sif.start_valid) begin
            if ((w_state[sif.start_tid] == TS_IDLE) || (w_state[sif.start_tid] == TS_HALTED)) begin
                w_pc[sif.start_tid]    = sif.start_pc;
                w_state[sif.start_tid] = TS_READY;
                w_kill[sif.start_tid]  = 1'b0;
            end else begin
                w_cmd_err = 1'b1;
            end
        end

        for (int unsigned t = 0; t < NUM_THREADS; t++) begin
            w_thread_active[TID_W'(t)] = is_live(w_state[TID_W'(t)]);
        end
    end

    // State register; reset drops everything in flight and reboots thread 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                r_state[TID_W'(t)] <= (t == 0) ? TS_READY : TS_IDLE;
                r_pc[TID_W'(t)]    <= (t == 0) ? RESET_PC : '0;
            end
            r_kill          <= '0;
            r_rr_ptr        <= TID_W'(NUM_THREADS - 1);
            r_issue_valid   <= 1'b0;
            r_issue         <= '0;
            r_cmd_err       <= 1'b0;
            r_thread_active <= NUM_THREADS'(1);
        end else begin
            r_state         <= w_state;
            r_pc            <= w_pc;
            r_kill          <= w_kill;
            r_rr_ptr        <= w_rr_ptr;
            r_issue_valid   <= w_issue_valid;
            r_issue         <= w_issue;
            r_cmd_err       <= w_cmd_err;
            r_thread_active <= w_thread_active;
        end
    end

    assign sif.issue_valid   = r_issue_valid;
    assign sif.thread_id     = r_issue.tid;
    assign sif.issue_pc      = r_issue.pc;
    assign sif.cmd_err       = r_cmd_err;
    assign sif.thread_active = r_thread_active;

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: expected issues are queued as stimulus
// is driven and popped when the scheduler presents an issue slot.
module tb_thread_scheduler;
    import thread_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    issue_t exp_q[$];

    thread_scheduler_if sif();

    thread_scheduler dut (
        .clk (clk),
        .rst (rst),
        .sif (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        sif.wb_valid    = 1'b0;
        sif.wb_tid      = '0;
        sif.wb_pc       = '0;
        sif.wb_halt     = 1'b0;
        sif.start_valid = 1'b0;
        sif.start_tid   = '0;
        sif.start_pc    = '0;
        sif.stop_valid  = 1'b0;
        sif.stop_tid    = '0;
    endtask

    task automatic do_wb(input int tid, input int pc, input logic halt);
        sif.wb_valid = 1'b1;
        sif.wb_tid   = TID_W'(tid);
        sif.wb_pc    = PC_W'(pc);
        sif.wb_halt  = halt;
    endtask

    task automatic do_start(input int tid, input int pc);
        sif.start_valid = 1'b1;
        sif.start_tid   = TID_W'(tid);
        sif.start_pc    = PC_W'(pc);
    endtask

    task automatic do_stop(input int tid);
        sif.stop_valid = 1'b1;
        sif.stop_tid   = TID_W'(tid);
    endtask

    task automatic push_issue(input int tid, input int pc);
        issue_t e;
        e.tid = TID_W'(tid);
        e.pc  = PC_W'(pc);
        exp_q.push_back(e);
    endtask

    task automatic check_issue(input string tag);
        issue_t e;
        n_tests++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected a queued issue", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 32'(sif.issue_valid), 32'd1);
            chk({tag, "_tid"},   32'(sif.thread_id),   32'(e.tid));
            chk({tag, "_pc"},    32'(sif.issue_pc),    32'(e.pc));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(sif.issue_valid), 32'd0);
    endtask

    task automatic check_hold(input string tag, input int tid, input int pc);
        chk({tag, "_valid"}, 32'(sif.issue_valid), 32'd1);
        chk({tag, "_tid"},   32'(sif.thread_id),   32'(tid));
        chk({tag, "_pc"},    32'(sif.issue_pc),    32'(pc));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"},  32'(sif.issue_valid),   32'd0);
        chk({tag, "_tid"},    32'(sif.thread_id),     32'd0);
        chk({tag, "_pc"},     32'(sif.issue_pc),      32'd0);
        chk({tag, "_err"},    32'(sif.cmd_err),       32'd0);
        chk({tag, "_active"}, 32'(sif.thread_active), 32'b0001);
    endtask

    initial begin
        int t;
        int p;
        int base [NUM_THREADS];

        rst = 1'b0;
        sif.stall = 1'b0;
        clr();
        tick();
        tick();
        check_reset("reset");

        // Boot: thread 0 issues once at RESET_PC, then nothing until it writes back
        rst = 1'b1;
        push_issue(0, int'(RESET_PC));
        tick();
        check_issue("boot");
        chk("boot_active", 32'(sif.thread_active), 32'b0001);
        tick();
        check_idle("boot_idle0");
        tick();
        check_idle("boot_idle1");

        // Load threads 1..3 and return thread 0 while stalled
        sif.stall = 1'b1;
        do_start(1, 'h100);
        do_wb(0, 'h001, 1'b0);
        tick();
        clr();
        do_start(2, 'h200);
        tick();
        clr();
        do_start(3, 'h300);
        tick();
        clr();
        chk("load_active", 32'(sif.thread_active), 32'b1111);
        check_idle("load_hold");

        // Two full rounds, writeback one cycle after each issue with pc+1
        base[0] = 'h001;
        base[1] = 'h100;
        base[2] = 'h200;
        base[3] = 'h300;
        sif.stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            t = (i + 1) % NUM_THREADS;
            p = base[t] + (i / NUM_THREADS);
            push_issue(t, p);
            tick();
            check_issue("rr");
            clr();
            do_wb(t, p + 1, 1'b0);
            if (i == 7) sif.stall = 1'b1;
        end
        tick();
        clr();
        check_hold("rr_stall", 0, 'h002);

        // Leave only 0 and 2 ready with rr_ptr=3 to exercise wrap-around
        do_stop(1);
        tick();
        clr();
        do_stop(2);
        tick();
        clr();
        chk("wrap_active", 32'(sif.thread_active), 32'b1001);
        sif.stall = 1'b0;
        do_start(2, 'h202);
        push_issue(3, 'h302);
        tick();
        clr();
        check_issue("wrap_t3");
        push_issue(0, 'h003);
        tick();
        check_issue("wrap_t0");
        push_issue(2, 'h202);
        tick();
        check_issue("wrap_t2");

        // Stall for three cycles with thread 3 becoming ready underneath
        sif.stall = 1'b1;
        do_wb(3, 'h303, 1'b0);
        tick();
        clr();
        check_hold("stall0", 2, 'h202);
        tick();
        check_hold("stall1", 2, 'h202);
        tick();
        check_hold("stall2", 2, 'h202);
        chk("stall_active", 32'(sif.thread_active), 32'b1101);
        sif.stall = 1'b0;
        push_issue(3, 'h303);
        tick();
        check_issue("unstall");

        // Stop thread 1 while in flight; its writeback parks it
        do_start(1, 'h104);
        tick();
        clr();
        check_idle("kill_start");
        push_issue(1, 'h104);
        tick();
        check_issue("kill_issue");
        do_stop(1);
        tick();
        clr();
        check_idle("kill_stop");
        chk("kill_active_pend", 32'(sif.thread_active), 32'b1111);
        do_wb(1, 'h105, 1'b0);
        tick();
        clr();
        chk("kill_active", 32'(sif.thread_active), 32'b1101);
        check_idle("kill_wb");
        tick();
        check_idle("kill_noissue");
        do_start(1, 'h400);
        tick();
        clr();
        check_idle("restart");
        push_issue(1, 'h400);
        tick();
        check_issue("restart");

        // Start to a READY thread is rejected and leaves its PC alone
        sif.stall = 1'b1;
        do_wb(0, 'h010, 1'b0);
        tick();
        clr();
        do_start(0, 'h777);
        tick();
        clr();
        sif.stall = 1'b0;
        do_start(2, 'h777);
        push_issue(0, 'h010);
        tick();
        clr();
        check_issue("err_ready");
        chk("err_inflight", 32'(sif.cmd_err), 32'd1);
        tick();
        check_idle("err_clear");
        chk("err_pulse", 32'(sif.cmd_err), 32'd0);
        do_wb(1, 'h401, 1'b0);
        do_start(1, 'h999);
        tick();
        clr();
        chk("err_wb_start", 32'(sif.cmd_err), 32'd1);
        check_idle("err_wb_start");
        push_issue(1, 'h401);
        tick();
        check_issue("err_wb_pc");
        chk("err_wb_clear", 32'(sif.cmd_err), 32'd0);

        // Halt thread 0, then reset in the middle of traffic
        do_wb(0, 'h011, 1'b1);
        tick();
        clr();
        chk("halt_active", 32'(sif.thread_active), 32'b1110);
        check_idle("halt0");
        tick();
        check_idle("halt1");
        do_wb(2, 'h203, 1'b0);
        tick();
        clr();
        rst = 1'b0;
        do_wb(3, 'h304, 1'b0);
        tick();
        clr();
        check_reset("mid_reset");
        rst = 1'b1;
        push_issue(0, int'(RESET_PC));
        tick();
        check_issue("reboot");
        chk("reboot_active", 32'(sif.thread_active), 32'b0001);
        tick();
        check_idle("reboot_idle");

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
